ahfp_float_2_fixed_pipe: RTL and testbench

- Converts IEEE-754 single-precision floats to signed two's-complement fixed point, Q3.29 by default (sign, 2 integer bits, FRAC_BITS fraction bits).
- Inverse of the fixed-to-float path.
- 3-stage pipeline with valid/ready handshakes on both sides. Sits between the float datapath and the fixed-point accumulators.
- Rounds to nearest, ties to even, and saturates when the result is out of range.

---
 rtl/ahfp_pkg.sv | 31 +++
 rtl/ahfp_rshift_sticky.sv | 28 ++
 rtl/ahfp_float_2_fixed_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_ahfp_float_2_fixed_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared float-datapath definitions: IEEE-754 single field widths, operand
// classes and fixed-point saturation limits.
package ahfp_pkg;

    localparam int unsigned FP_EXP_BIAS = 127;
    localparam int unsigned FP_MAN_W    = 23;
    localparam int unsigned FP_EXP_W    = 8;

    localparam logic [31:0] FIX_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] FIX_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Denormals fall into FP_ZERO: this datapath flushes them.
    function automatic fp_class_t fp_classify(input logic [FP_EXP_W-1:0] expo,
                                              input logic [FP_MAN_W-1:0] man);
        if (expo == '0) begin
            return FP_ZERO;
        end
        if (expo == '1) begin
            return (man != '0) ? FP_NAN : FP_INF;
        end
        return FP_NORMAL;
    endfunction

endpackage

// File: rtl/ahfp_rshift_sticky.sv
// Combinational 24-bit right shifter producing the shifted magnitude plus the
// guard bit and sticky OR needed for round-to-nearest-even.
module ahfp_rshift_sticky (
    input  logic [23:0] m,
    input  logic [4:0]  amt,
    output logic [23:0] mag,
    output logic        guard,
    output logic        sticky
);

    logic [47:0] ext;

    // Shift into a double-width field: the upper half is the result, bit 23 the
    // guard and the rest collapses to sticky. Shifts of 25+ leave only sticky.
    always_comb begin
        ext = {m, 24'd0} >> amt;
        if (amt >= 5'd25) begin
            mag    = '0;
            guard  = 1'b0;
            sticky = 1'b1;
        end else begin
            mag    = ext[47:24];
            guard  = ext[23];
            sticky = |ext[22:0];
        end
    end

endmodule

// File: rtl/ahfp_float_2_fixed_pipe.sv
// IEEE-754 single to signed 32-bit fixed point (FRAC_BITS fraction bits).
// Three-stage valid/ready pipeline: unpack/classify, shift, round/saturate.
module ahfp_float_2_fixed_pipe
    import ahfp_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 29
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_inexact
);

    // s = exp - bias + FRAC_BITS - 23, computed as exp - S_OFFSET mod 2^10.
    localparam logic [9:0] S_OFFSET = 10'(FP_EXP_BIAS + FP_MAN_W - FRAC_BITS);

    logic s1_adv, s2_adv, s3_adv;

    logic              s1_valid_q;
    logic              s1_sign_q;
    fp_class_t         s1_class_q;
    logic [23:0]       s1_m_q;
    logic signed [9:0] s1_s_q;

    logic              s2_valid_q;
    logic              s2_sign_q;
    fp_class_t         s2_class_q;
    logic [31:0]       s2_mag_q;
    logic              s2_guard_q;
    logic              s2_sticky_q;
    logic              s2_ovf_q;

    logic              s3_valid_q;
    logic [31:0]       s3_data_q;
    logic              s3_ovf_q;
    logic              s3_inexact_q;

    // Each stage moves when it is empty or its successor moves.
    always_comb begin
        s3_adv   = !s3_valid_q || out_ready;
        s2_adv   = !s2_valid_q || s3_adv;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // S1: unpack fields, classify and compute the signed scale exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_class_q <= FP_ZERO;
            s1_m_q     <= '0;
            s1_s_q     <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q  <= in_data[31];
                s1_class_q <= fp_classify(in_data[30:23], in_data[22:0]);
                s1_m_q     <= {1'b1, in_data[22:0]};
                s1_s_q     <= $signed({2'b00, in_data[30:23]} - S_OFFSET);
            end
        end
    end

    logic [9:0]  rs_neg;
    logic [4:0]  rs_amt;
    logic [23:0] rs_mag;
    logic        rs_guard;
    logic        rs_sticky;

    // Right-shift amount for s < 0, clamped to the shifter's 0..31 range.
    always_comb begin
        rs_neg = -s1_s_q;
        rs_amt = (rs_neg > 10'd31) ? 5'd31 : rs_neg[4:0];
    end

    ahfp_rshift_sticky u_rshift (
        .m      (s1_m_q),
        .amt    (rs_amt),
        .mag    (rs_mag),
        .guard  (rs_guard),
        .sticky (rs_sticky)
    );

    logic [32:0] l_mag;
    logic        l_big;
    logic [31:0] s2_mag_d;
    logic        s2_guard_d;
    logic        s2_sticky_d;
    logic        s2_ovf_d;

    // S2 next state: left shift with overflow detect, or right shift with
    // guard/sticky. Zero class carries its flush-inexact in sticky.
    always_comb begin
        l_big       = s1_s_q > 10'sd8;
        l_mag       = {9'd0, s1_m_q} << s1_s_q[3:0];
        s2_mag_d    = '0;
        s2_guard_d  = 1'b0;
        s2_sticky_d = 1'b0;
        s2_ovf_d    = 1'b0;
        unique case (s1_class_q)
            FP_ZERO: begin
                s2_sticky_d = |s1_m_q[22:0];
            end
            FP_NORMAL: begin
                if (!s1_s_q[9]) begin
                    // -2^31 is the one magnitude of 2^31 that still fits.
                    s2_ovf_d = l_big || l_mag[32] ||
                               (l_mag[31] && !(s1_sign_q && l_mag[30:0] == '0));
                    s2_mag_d = l_mag[31:0];
                end else begin
                    s2_mag_d    = {8'd0, rs_mag};
                    s2_guard_d  = rs_guard;
                    s2_sticky_d = rs_sticky;
                end
            end
            default: begin
            end
        endcase
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_class_q  <= FP_ZERO;
            s2_mag_q    <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_ovf_q    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q   <= s1_sign_q;
                s2_class_q  <= s1_class_q;
                s2_mag_q    <= s2_mag_d;
                s2_guard_q  <= s2_guard_d;
                s2_sticky_q <= s2_sticky_d;
                s2_ovf_q    <= s2_ovf_d;
            end
        end
    end

    logic [31:0] rounded;
    logic [31:0] s3_data_d;
    logic        s3_ovf_d;
    logic        s3_inexact_d;

    // S3 next state: round half to even, apply sign, saturate or substitute
    // the fixed result for specials. Right-shifted values are < 2^24, so the
    // round-up increment cannot carry out.
    always_comb begin
        rounded      = s2_mag_q + {31'd0, s2_guard_q & (s2_sticky_q | s2_mag_q[0])};
        s3_data_d    = '0;
        s3_ovf_d     = 1'b0;
        s3_inexact_d = 1'b0;
        unique case (s2_class_q)
            FP_ZERO: begin
                s3_inexact_d = s2_sticky_q;
            end
            FP_NORMAL: begin
                if (s2_ovf_q) begin
                    s3_data_d = s2_sign_q ? FIX_MIN : FIX_MAX;
                    s3_ovf_d  = 1'b1;
                end else begin
                    s3_data_d    = s2_sign_q ? (~rounded + 32'd1) : rounded;
                    s3_inexact_d = s2_guard_q | s2_sticky_q;
                end
            end
            FP_INF: begin
                s3_data_d = s2_sign_q ? FIX_MIN : FIX_MAX;
                s3_ovf_d  = 1'b1;
            end
            FP_NAN: begin
                s3_data_d = FIX_MAX;
                s3_ovf_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // S3 / output register; holds while stalled by out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q   <= 1'b0;
            s3_data_q    <= '0;
            s3_ovf_q     <= 1'b0;
            s3_inexact_q <= 1'b0;
        end else if (s3_adv) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_data_q    <= s3_data_d;
                s3_ovf_q     <= s3_ovf_d;
                s3_inexact_q <= s3_inexact_d;
            end
        end
    end

    // Output drive.
    always_comb begin
        out_valid   = s3_valid_q;
        out_data    = s3_data_q;
        out_ovf     = s3_ovf_q;
        out_inexact = s3_inexact_q;
    end

endmodule

// File: tb/tb_ahfp_float_2_fixed_pipe.sv
// Self-checking bench for ahfp_float_2_fixed_pipe (FRAC_BITS = 29).
module tb_ahfp_float_2_fixed_pipe;

    localparam int FB = 29;
    localparam logic [31:0] MAXV = 32'h7FFF_FFFF;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_inexact;

    int n_checks = 0;
    int n_err    = 0;
    int n_out    = 0;
    logic [33:0] exp_q[$];

    ahfp_float_2_fixed_pipe #(.FRAC_BITS(FB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact value f * 2^FB, rounded half-to-even, then saturated.
    function automatic logic [33:0] model(input logic [31:0] f);
        int     e;
        int     k;
        int     d;
        longint m;
        longint q;
        longint rem;
        longint half;
        longint v;
        logic   inx;
        e = int'(f[30:23]);
        if (e == 0) return {32'd0, 1'b0, f[22:0] != 0};
        if (e == 255) begin
            if (f[22:0] != 0) return {MAXV, 2'b10};
            return {(f[31] ? MINV : MAXV), 2'b10};
        end
        m   = longint'({1'b1, f[22:0]});
        k   = e - (150 - FB);
        inx = 1'b0;
        if (k >= 0) begin
            q = (k > 32) ? (longint'(1) << 40) : (m << k);
        end else begin
            d = -k;
            if (d >= 40) begin
                q   = 0;
                inx = 1'b1;
            end else begin
                q    = m >> d;
                rem  = m - (q << d);
                half = longint'(1) << (d - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
                inx = (rem != 0);
            end
        end
        v = f[31] ? -q : q;
        if (v > 64'sd2147483647) return {MAXV, 2'b10};
        if (v < -64'sd2147483648) return {MINV, 2'b10};
        return {v[31:0], 1'b0, inx};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: e = r[30:23];
            1: e = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            default: e = 8'($urandom_range(80, 135));
        endcase
        return {r[31], e, r[22:0]};
    endfunction

    // One clock: drive at negedge, observe #1 later, scoreboard both sides.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                        output logic fired);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        fired = iv && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 34'(out_valid), 34'd0);
            end else begin
                chk("stream_out", {out_data, out_ovf, out_inexact}, exp_q.pop_front());
            end
        end
        if (fired) exp_q.push_back(model(d));
        @(posedge clk);
    endtask

    // Single item with out_ready high: checks latency and the result.
    task automatic run_vec(input string tag, input logic [31:0] d, input logic [33:0] expv);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 34'(in_ready), 34'd1);
        @(posedge clk);
        for (n = 1; n < 10; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) break;
            @(posedge clk);
        end
        chk({tag, "_lat"}, 34'(n), 34'd3);
        chk(tag, {out_data, out_ovf, out_inexact}, expv);
        @(posedge clk);
    endtask

    initial begin
        logic        f;
        int          sent;
        int          cyc;
        int          base;
        logic [31:0] cur;
        logic [31:0] vec [6];
        logic [33:0] snap;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #23;
        chk("rst_state", {out_valid, out_data, out_ovf, out_inexact}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 34'(in_ready), 34'd1);
        chk("rst_out_valid", 34'(out_valid), 34'd0);

        run_vec("one",      32'h3F80_0000, {32'h2000_0000, 2'b00});
        run_vec("m1p5",     32'hBFC0_0000, {32'hD000_0000, 2'b00});
        run_vec("tie_zero", 32'h3080_0000, {32'h0000_0000, 2'b01});
        run_vec("tie_even", 32'h3140_0000, {32'h0000_0002, 2'b01});
        run_vec("denorm",   32'h0000_0001, {32'h0000_0000, 2'b01});
        run_vec("five",     32'h40A0_0000, {MAXV, 2'b10});
        run_vec("m4",       32'hC080_0000, {MINV, 2'b00});
        run_vec("ninf",     32'hFF80_0000, {MINV, 2'b10});
        run_vec("pinf",     32'h7F80_0000, {MAXV, 2'b10});
        run_vec("nan",      32'h7FC0_0000, {MAXV, 2'b10});
        run_vec("neg_nan",  32'hFFC0_0001, {MAXV, 2'b10});
        run_vec("neg_zero", 32'h8000_0000, {32'h0000_0000, 2'b00});

        // Backpressure: 5 items offered while the output is stalled.
        for (int i = 0; i < 5; i++) vec[i] = {$urandom_range(0, 1) != 0, 8'(120 + i), 23'($urandom)};
        vec[5] = '0;
        sent = 0;
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            step(sent < 5, vec[sent], 1'b0, f);
            if (f) sent++;
        end
        chk("bp_accepted", 34'(sent), 34'd3);
        @(negedge clk);
        #1;
        chk("bp_in_ready", 34'(in_ready), 34'd0);
        chk("bp_out_valid", 34'(out_valid), 34'd1);
        snap = {out_data, out_ovf, out_inexact};
        chk("bp_head", snap, model(vec[0]));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vec[sent], 1'b0, f);
            if (f) sent++;
        end
        @(negedge clk);
        #1;
        chk("bp_stable", {out_data, out_ovf, out_inexact}, snap);
        cyc = 0;
        while ((sent < 5 || exp_q.size() != 0) && cyc < 40) begin
            step(sent < 5, vec[sent], 1'b1, f);
            if (f) sent++;
            cyc++;
        end
        chk("bp_count", 34'(n_out - base), 34'd5);

        // Random traffic with 50% valid and 50% ready.
        sent = 0;
        cyc  = 0;
        cur  = rand_float();
        while (sent < 10000 && cyc < 60000) begin
            step($urandom_range(0, 1) != 0, cur, $urandom_range(0, 1) != 0, f);
            if (f) begin
                sent++;
                cur = rand_float();
            end
            cyc++;
        end
        chk("rand_sent", 34'(sent), 34'd10000);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step(1'b0, 32'd0, 1'b1, f);
            cyc++;
        end
        chk("rand_drain", 34'(exp_q.size()), 34'd0);

        // Reset with items in flight.
        step(1'b1, 32'h3F80_0000, 1'b0, f);
        step(1'b1, 32'h4000_0000, 1'b0, f);
        step(1'b0, 32'd0, 1'b0, f);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", 34'(out_valid), 34'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {out_valid, out_data, out_ovf, out_inexact}, 34'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = n_out;
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1, f);
        chk("post_rst_quiet", 34'(n_out - base), 34'd0);
        run_vec("post_rst", 32'h3F80_0000, {32'h2000_0000, 2'b00});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
